// File: rtl/credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : credit_tx
// Description : Credit-based link transmitter. Accepts flits from an upstream
//               valid/ready source and forwards them onto a link that has no
//               backpressure. Each flit sent consumes one receiver credit, and
//               each credit_return pulse gives one credit back. A flush drains
//               the link until every credit has been returned.
// Ports       :
//   clk, rst          - single clock; synchronous active-high reset
//   s_valid/s_ready   - upstream handshake; s_data is the flit payload
//   link_valid        - one-cycle pulse per flit on the link; link_data payload
//   credit_return     - one credit returned per high cycle
//   credit_init       - loads MAX_CREDIT credits and enables the link
//   flush_req         - level; hold off new traffic until all credits return
//   credits           - current credit count
//   idle              - all credits home and the link is active
//   overflow_err      - sticky; a credit came back while already full
// Revision    : 1.0 - initial release
// ============================================================================
module credit_tx #(
  parameter int DATA_W     = 32,
  parameter int MAX_CREDIT = 8,
  parameter int CNT_W      = $clog2(MAX_CREDIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              link_valid,
  output logic [DATA_W-1:0] link_data,
  input  logic              credit_return,
  input  logic              credit_init,
  input  logic              flush_req,
  output logic [CNT_W-1:0]  credits,
  output logic              idle,
  output logic              overflow_err
);

  localparam logic [1:0] c_S_INIT   = 2'd0;
  localparam logic [1:0] c_S_ACTIVE = 2'd1;
  localparam logic [1:0] c_S_FLUSH  = 2'd2;

  localparam logic [CNT_W-1:0] c_MAX_CREDIT = CNT_W'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_credits;
  logic              r_link_valid;
  logic [DATA_W-1:0] r_link_data;
  logic              r_overflow_err;

  logic w_accept;
  logic w_counting;
  logic w_full;

  assign w_full     = (r_credits == c_MAX_CREDIT);
  assign s_ready    = (r_state == c_S_ACTIVE) && (r_credits != '0);
  assign w_accept   = s_valid && s_ready;
  // Returns are only meaningful once the link has been initialised.
  assign w_counting = (r_state == c_S_ACTIVE) || (r_state == c_S_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_S_INIT;
      r_credits      <= '0;
      r_link_valid   <= 1'b0;
      r_link_data    <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      r_link_valid <= w_accept;
      if (w_accept) begin
        r_link_data <= s_data;
      end

      // Credit accounting: an accept and a return in the same cycle cancel.
      if (w_counting) begin
        if (w_accept && !credit_return) begin
          r_credits <= r_credits - c_ONE;
        end else if (!w_accept && credit_return) begin
          if (w_full) begin
            r_overflow_err <= 1'b1;
          end else begin
            r_credits <= r_credits + c_ONE;
          end
        end
      end

      case (r_state)
        c_S_INIT: begin
          if (credit_init) begin
            r_state   <= c_S_ACTIVE;
            r_credits <= c_MAX_CREDIT;
          end
        end
        c_S_ACTIVE: begin
          if (flush_req) begin
            r_state <= c_S_FLUSH;
          end
        end
        c_S_FLUSH: begin
          // Leave only once the drain is complete and nobody still wants it.
          if (w_full && !flush_req) begin
            r_state <= c_S_ACTIVE;
          end
        end
        default: begin
          r_state <= c_S_INIT;
        end
      endcase
    end
  end

  assign link_valid   = r_link_valid;
  assign link_data    = r_link_data;
  assign credits      = r_credits;
  assign overflow_err = r_overflow_err;
  assign idle         = (r_state == c_S_ACTIVE) && w_full;

endmodule
`default_nettype wire

// File: tb/tb_credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_tx
// Description : Scoreboard bench for credit_tx. The driver pushes the payload
//               of every flit it expects to be accepted; a monitor pops and
//               compares on every link_valid pulse. State/credit checks use
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_tx;

  localparam int DATA_W     = 32;
  localparam int MAX_CREDIT = 8;
  localparam int CNT_W      = $clog2(MAX_CREDIT + 1);

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              link_valid;
  logic [DATA_W-1:0] link_data;
  logic              credit_return;
  logic              credit_init;
  logic              flush_req;
  logic [CNT_W-1:0]  credits;
  logic              idle;
  logic              overflow_err;

  credit_tx #(
    .DATA_W    (DATA_W),
    .MAX_CREDIT(MAX_CREDIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .link_valid   (link_valid),
    .link_data    (link_data),
    .credit_return(credit_return),
    .credit_init  (credit_init),
    .flush_req    (flush_req),
    .credits      (credits),
    .idle         (idle),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_rx    = 0;

  logic [DATA_W-1:0] exp_q[$];

  // Expected-behaviour model of the upstream side: decides which flits
  // should be accepted so that their payloads can be queued.
  int m_st = 0;  // 0 INIT, 1 ACTIVE, 2 FLUSH
  int m_cr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic cyc();
    bit acc;
    int pre_cr;
    acc    = !rst && s_valid && (m_st == 1) && (m_cr != 0);
    pre_cr = m_cr;
    if (acc) exp_q.push_back(s_data);
    @(posedge clk);
    if (rst) begin
      m_st = 0;
      m_cr = 0;
    end else if (m_st == 0) begin
      if (credit_init) begin
        m_st = 1;
        m_cr = MAX_CREDIT;
      end
    end else begin
      if (acc && !credit_return) m_cr = m_cr - 1;
      else if (!acc && credit_return && m_cr < MAX_CREDIT) m_cr = m_cr + 1;
      if (m_st == 1 && flush_req) m_st = 2;
      else if (m_st == 2 && pre_cr == MAX_CREDIT && !flush_req) m_st = 1;
    end
    #1;
  endtask

  // Monitor: every link pulse must match the oldest queued payload.
  always @(negedge clk) begin
    if (link_valid) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL link_unexpected: got data %0h expected no flit", link_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (link_data === e) n_pass++;
        else $display("FAIL link_data: got %0h expected %0h", link_data, e);
      end
      n_rx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    int rx0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; credit_return = 1'b0;
    credit_init = 1'b0; flush_req = 1'b0;
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;
    chk("rst_credits", 32'(credits), 0);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_idle", 32'(idle), 0);
    chk("rst_link_valid", 32'(link_valid), 0);
    chk("rst_link_data", link_data, 0);
    chk("rst_ovf", 32'(overflow_err), 0);

    // Returns before init are ignored.
    credit_return = 1'b1; cyc(); credit_return = 1'b0;
    chk("init_ret_ignored", 32'(credits), 0);
    chk("init_ovf", 32'(overflow_err), 0);

    credit_init = 1'b1; cyc(); credit_init = 1'b0;
    chk("init_credits", 32'(credits), 8);
    chk("init_idle", 32'(idle), 1);
    chk("init_ready", 32'(s_ready), 1);

    // Burst of 8 with no returns, then one more offer that must stall.
    rx0 = n_rx;
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 32'hA000_0000 + 32'(i);
      cyc();
    end
    chk("burst_credits", 32'(credits), 0);
    chk("burst_ready", 32'(s_ready), 0);
    chk("burst_idle", 32'(idle), 0);
    s_data = 32'hDEAD_0000;
    cyc();
    chk("burst_count", 32'(n_rx - rx0), 8);
    chk("zero_no_link", 32'(link_valid), 0);
    s_valid = 1'b0;

    // Zero boundary: a single return re-opens the gate for one flit.
    credit_return = 1'b1; cyc(); credit_return = 1'b0;
    chk("zero_ret_credits", 32'(credits), 1);
    chk("zero_ret_ready", 32'(s_ready), 1);
    s_valid = 1'b1; s_data = 32'h0000_BEEF; cyc(); s_valid = 1'b0;
    chk("zero_acc_credits", 32'(credits), 0);
    chk("zero_acc_ready", 32'(s_ready), 0);

    // Bring credits to 3, then 5 cycles of accept+return together.
    credit_return = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("pre_sim_credits", 32'(credits), 3);
    rx0 = n_rx;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 32'h5500_0000 + 32'(i);
      cyc();
      chk("sim_credits", 32'(credits), 3);
    end
    s_valid = 1'b0; credit_return = 1'b0;
    cyc();
    chk("sim_count", 32'(n_rx - rx0), 5);
    chk("sim_ovf", 32'(overflow_err), 0);

    // Fill to 8, then one extra return sets the sticky overflow.
    credit_return = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    credit_return = 1'b0;
    chk("full_credits", 32'(credits), 8);
    chk("full_ovf", 32'(overflow_err), 0);
    credit_return = 1'b1; cyc(); credit_return = 1'b0;
    chk("ovf_credits", 32'(credits), 8);
    chk("ovf_set", 32'(overflow_err), 1);
    cyc(); cyc();
    chk("ovf_sticky", 32'(overflow_err), 1);

    // Flush: drop to 5, request flush, drain with 3 returns.
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'hF100_0000 + 32'(i);
      cyc();
    end
    s_valid = 1'b0;
    chk("pre_flush_credits", 32'(credits), 5);
    flush_req = 1'b1; cyc();
    chk("flush_ready", 32'(s_ready), 0);
    s_valid = 1'b1; s_data = 32'hBAD0_0001; credit_return = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    credit_return = 1'b0;
    chk("flush_credits", 32'(credits), 8);
    chk("flush_idle", 32'(idle), 0);
    chk("flush_hold_ready", 32'(s_ready), 0);
    cyc();
    chk("flush_stay", 32'(idle), 0);
    s_valid = 1'b0; flush_req = 1'b0; cyc();
    chk("unflush_idle", 32'(idle), 1);
    chk("unflush_ready", 32'(s_ready), 1);
    chk("unflush_ovf", 32'(overflow_err), 1);

    // Reset mid-operation right after an accept.
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 32'hC000_0000 + 32'(i);
      cyc();
    end
    chk("pre_rst_credits", 32'(credits), 4);
    chk("pre_rst_link", 32'(link_valid), 1);
    s_data = 32'hBAD0_0002;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_credits", 32'(credits), 0);
    chk("mid_rst_link", 32'(link_valid), 0);
    chk("mid_rst_ready", 32'(s_ready), 0);
    chk("mid_rst_ovf", 32'(overflow_err), 0);
    cyc(); cyc();
    chk("post_rst_ready", 32'(s_ready), 0);
    s_valid = 1'b0;
    credit_init = 1'b1; cyc(); credit_init = 1'b0;
    chk("reinit_ready", 32'(s_ready), 1);
    chk("reinit_credits", 32'(credits), 8);

    cyc(); cyc();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/credit_tx.md
CREDIT_TX -- requirements
Module: credit_tx

Interface
REQ-001 Parameter DATA_W, default 32: width of payload flits.
REQ-002 Parameter MAX_CREDIT, default 8: number of receiver buffer slots (credits) on the link; legal range 1..255.
REQ-003 Parameter CNT_W, default $clog2(MAX_CREDIT+1): width of the credit counter.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_valid  input  1  upstream flit valid.
REQ-007 s_ready  output  1  upstream accept; transfer when s_valid && s_ready.
REQ-008 s_data  input  DATA_W  upstream flit payload.
REQ-009 link_valid  output  1  one-cycle pulse per flit sent on the link; the link has no backpressure.
REQ-010 link_data  output  DATA_W  flit payload, qualified by link_valid.
REQ-011 credit_return  input  1  one-cycle pulse from the receiver; each high cycle returns exactly one credit.
REQ-012 credit_init  input  1  pulse; loads MAX_CREDIT credits and enables the link.
REQ-013 flush_req  input  1  level; requests a drain until all credits are back.
REQ-014 credits  output  CNT_W  current credit count.
REQ-015 idle  output  1  high when credits == MAX_CREDIT and state is ACTIVE.
REQ-016 overflow_err  output  1  sticky error flag; set by a credit return while credits == MAX_CREDIT.

Function
REQ-017 The FSM SHALL have three states: INIT, ACTIVE and FLUSH.
REQ-018 INIT -> ACTIVE on credit_init, with credits loaded to MAX_CREDIT in the same edge; credit_return in INIT ignored; credit_init outside INIT ignored.
REQ-019 ACTIVE -> FLUSH when flush_req is high; FLUSH -> ACTIVE on the first cycle where credits == MAX_CREDIT and flush_req is low; remain in FLUSH while flush_req is high.
REQ-020 s_ready SHALL be combinational: (state == ACTIVE) && (credits != 0).
REQ-021 On accept, link_valid=1 and link_data=s_data on the next cycle (latency exactly 1); link_valid low otherwise; link_data holds its last value when link_valid is low.
REQ-022 Accept without return: credits decrements by 1 at the same edge.
REQ-023 Return without accept: credits increments by 1, saturating at MAX_CREDIT.
REQ-024 Simultaneous accept and return: credits unchanged, no error.
REQ-025 Return with no accept while credits == MAX_CREDIT: credits stays MAX_CREDIT and overflow_err is set; it is cleared only by rst.
REQ-026 In FLUSH, credit returns SHALL continue to be counted, with no accepts.
REQ-027 Credits at 0: s_ready low, no link_valid is generated, and no underflow is possible.
REQ-028 Back-to-back accepts SHALL be supported, up to one flit per cycle, until credits reach 0.
REQ-029 idle is a combinational decode of state and credits.

Reset
REQ-030 When rst is high at a clock edge: state=INIT, credits=0, link_valid=0, link_data=0, overflow_err=0; hence s_ready=0 and idle=0.
REQ-031 rst takes priority over every other input, including mid-transfer and mid-flush; no link_valid pulse is produced in the cycle after a reset edge.

Verification
REQ-032 Init and burst: after rst, pulse credit_init, MAX_CREDIT=8, s_valid held high, no returns -> exactly 8 link_valid pulses on consecutive cycles, each matching its s_data with 1-cycle latency; then s_ready=0 and credits=0.
REQ-033 Simultaneous events: credits=3, s_valid high and credit_return high for 5 cycles -> credits stays 3; 5 flits are sent.
REQ-034 Zero boundary: credits=0, one credit_return -> s_ready high the next cycle; one accept -> credits=0 again.
REQ-035 Overflow: credits=8, credit_return pulse with no accept -> credits=8 and overflow_err=1, which stays 1 until rst.
REQ-036 Flush: credits=5, assert flush_req -> s_ready=0 immediately; 3 returns -> credits=8; deassert flush_req -> ACTIVE and idle=1.
REQ-037 Reset mid-operation: rst while credits=4 and a flit was accepted in the previous cycle -> next cycle credits=0, link_valid=0, state=INIT; credit_init is required before any further s_ready.
